// File: rtl/rx_pkg.sv
// Shared constants and the sample vote for the UART receive oversampler.
package rx_pkg;
   localparam int NSAMP_3      = 3;
   localparam int NSAMP_5      = 5;
   localparam int MAX_PRESCALE = 32;
   localparam logic LINE_IDLE  = 1'b1;

   typedef struct packed {
      logic noise;
      logic bit_val;
   } vote_t;

   // 3-sample mode votes on the centre three entries s[3:1].
   function automatic vote_t vote_samples(input logic [NSAMP_5-1:0] s, input logic five);
      vote_t v;
      logic [2:0] ones;
      if (five) begin
         ones      = 3'(s[0]) + 3'(s[1]) + 3'(s[2]) + 3'(s[3]) + 3'(s[4]);
         v.bit_val = (ones >= 3'((NSAMP_5 + 1) / 2));
         v.noise   = (s != '1) && (s != '0);
      end else begin
         ones      = 3'(s[1]) + 3'(s[2]) + 3'(s[3]);
         v.bit_val = (ones >= 3'((NSAMP_3 + 1) / 2));
         v.noise   = (s[3:1] != 3'b111) && (s[3:1] != 3'b000);
      end
      return v;
   endfunction
endpackage

// File: rtl/rx_sync.sv
// Input synchroniser chain; resets to the idle line level so reset never looks like a start bit.
module rx_sync
   import rx_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic d,
   output logic q
);

   generate
      if (STAGES == 0) begin : g_bypass
         assign q = d;
      end else begin : g_chain
         logic [STAGES-1:0] ff;

         always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
               ff <= {STAGES{LINE_IDLE}};
            end else begin
               ff[0] <= d;
               for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
            end
         end

         assign q = ff[STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/rx_oversampler.sv
// UART bit recovery: per-bit edge counter, 3/5 mid-bit samples, registered majority vote.
module rx_oversampler
   import rx_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int PRESCALE_W  = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [PRESCALE_W-1:0] PRESCALE,
   input  logic                  SAMPLE_EN,
   input  logic                  FIVE_SAMPLE,
   output logic [PRESCALE_W-1:0] EDGE_CNT,
   output logic                  BIT_VALID,
   output logic                  S_BIT,
   output logic                  NOISE
);

   logic                  rx_s;
   logic [PRESCALE_W-1:0] last_edge;
   logic [PRESCALE_W-1:0] mid;
   logic [NSAMP_5-1:0]    samp;
   logic [NSAMP_5-1:0]    samp_next;
   logic                  five_mode;
   logic                  bit_done;
   vote_t                 vote;

   rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .CLK (CLK),
      .RST (RST),
      .d   (RX_IN),
      .q   (rx_s)
   );

   assign last_edge = PRESCALE - PRESCALE_W'(1);
   assign mid       = PRESCALE >> 1;
   assign five_mode = FIVE_SAMPLE && (PRESCALE != PRESCALE_W'(4));
   assign bit_done  = SAMPLE_EN && (EDGE_CNT == last_edge);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)                EDGE_CNT <= '0;
      else if (!SAMPLE_EN)     EDGE_CNT <= '0;
      else if (bit_done)       EDGE_CNT <= '0;
      else                     EDGE_CNT <= EDGE_CNT + PRESCALE_W'(1);
   end

   // Sample i sits at mid-2+i. At PRESCALE=4 the last point coincides with the
   // completion edge, so the vote looks at the post-capture vector.
   always_comb begin
      samp_next = samp;
      if (SAMPLE_EN) begin
         for (int i = 0; i < NSAMP_5; i++) begin
            if (EDGE_CNT == mid + PRESCALE_W'(i) - PRESCALE_W'(2)) samp_next[i] = rx_s;
         end
      end
   end

   assign vote = vote_samples(samp_next, five_mode);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) samp <= {NSAMP_5{LINE_IDLE}};
      else      samp <= samp_next;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         BIT_VALID <= 1'b0;
         S_BIT     <= LINE_IDLE;
         NOISE     <= 1'b0;
      end else begin
         BIT_VALID <= bit_done;
         if (bit_done) begin
            S_BIT <= vote.bit_val;
            NOISE <= vote.noise;
         end
      end
   end

endmodule
